// File: rtl/spi_target_wb_if.sv
// Wishbone classic slave bus bundle for the SPI target endpoint.
interface spi_target_wb_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/spi_target_wb.sv
// SPI mode-0 target with one RX and one TX byte buffer behind a Wishbone slave.
// Optional level interrupt output when SPI_TARGET_IRQ_EN is defined.
module spi_target_wb #(
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    spi_target_wb_if.slave  wb,
    input  logic            spi_ss_n,
    input  logic            spi_sck,
    input  logic            spi_mosi,
    output logic            spi_miso,
    output logic            spi_miso_oe
`ifdef SPI_TARGET_IRQ_EN
    ,
    output logic            irq
`endif
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEL  = 1'b1
    } state_e;

    state_e                  state;
    logic [SYNC_STAGES-1:0]  ss_sync;
    logic [SYNC_STAGES-1:0]  sck_sync;
    logic [SYNC_STAGES-1:0]  mosi_sync;
    logic                    ss_d;
    logic                    sck_d;

    logic [CNT_W-1:0]        bit_cnt;
    logic [BYTE_W-1:0]       rx_shift;
    logic [BYTE_W-1:0]       tx_shift;
    logic [BYTE_W-1:0]       rx_data;
    logic [BYTE_W-1:0]       tx_hold;
    logic                    rx_valid;
    logic                    tx_full;
    logic                    rx_ovr;
    logic                    tx_udr;
    logic                    enable;
`ifdef SPI_TARGET_IRQ_EN
    logic                    ie_rx;
    logic                    ie_tx;
    logic                    ie_err;
`endif

    logic                    ss_s_c, sck_s_c, mosi_s_c;
    logic                    ss_fall_c, sck_rise_c, sck_fall_c;
    logic                    start_c, leave_c, run_c;
    logic                    rise_c, fall_c, byte_done_c, reload_c, rx_take_c;
    logic [BYTE_W-1:0]       reload_val_c;
    logic [BYTE_W-1:0]       rx_byte_c;
    logic                    acc_c, data_rd_c, data_wr_c, stat_wr_c, ctrl_wr_c;
    logic [1:0]              reg_sel_c;
    logic [31:0]             rd_data_c;
    logic                    unused_bits_c;

    assign ss_s_c   = ss_sync[SYNC_STAGES-1];
    assign sck_s_c  = sck_sync[SYNC_STAGES-1];
    assign mosi_s_c = mosi_sync[SYNC_STAGES-1];

    // Event decode: frame start/stop, SCK edges and byte boundaries
    always_comb begin
        ss_fall_c    = ss_d & ~ss_s_c;
        sck_rise_c   = sck_s_c & ~sck_d;
        sck_fall_c   = ~sck_s_c & sck_d;
        start_c      = (state == ST_IDLE) & ss_fall_c & enable;
        leave_c      = (state == ST_SEL) & (ss_s_c | ~enable);
        run_c        = (state == ST_SEL) & ~leave_c;
        rise_c       = run_c & sck_rise_c;
        fall_c       = run_c & sck_fall_c;
        byte_done_c  = rise_c & (bit_cnt == CNT_W'(7));
        reload_c     = start_c | (fall_c & (bit_cnt == CNT_W'(0)));
        reload_val_c = tx_full ? tx_hold : IDLE_BYTE;
        rx_byte_c    = {rx_shift[BYTE_W-2:0], mosi_s_c};
        // A DATA read in the completion cycle frees the slot for the new byte
        rx_take_c    = byte_done_c & (~rx_valid | data_rd_c);
    end

    // Bus access decode and read mux
    always_comb begin
        acc_c     = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
        reg_sel_c = wb.wb_adr_i[3:2];
        data_rd_c = acc_c & ~wb.wb_we_i & (reg_sel_c == 2'd0);
        data_wr_c = acc_c &  wb.wb_we_i & (reg_sel_c == 2'd0);
        stat_wr_c = acc_c &  wb.wb_we_i & (reg_sel_c == 2'd1);
        ctrl_wr_c = acc_c &  wb.wb_we_i & (reg_sel_c == 2'd2);
        rd_data_c = '0;
        case (reg_sel_c)
            2'd0: rd_data_c = 32'(rx_data);
            2'd1: rd_data_c = 32'({(state == ST_SEL), tx_udr, rx_ovr, ~tx_full, rx_valid});
`ifdef SPI_TARGET_IRQ_EN
            2'd2: rd_data_c = 32'({ie_err, ie_tx, ie_rx, enable});
`else
            2'd2: rd_data_c = 32'(enable);
`endif
            default: rd_data_c = '0;
        endcase
    end

    assign unused_bits_c = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_sel_i,
                             wb.wb_dat_i[31:8], rx_shift[BYTE_W-1], tx_shift[BYTE_W-1]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            ss_sync     <= '1;
            sck_sync    <= '0;
            mosi_sync   <= '0;
            ss_d        <= 1'b1;
            sck_d       <= 1'b0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rx_data     <= '0;
            tx_hold     <= '0;
            rx_valid    <= 1'b0;
            tx_full     <= 1'b0;
            rx_ovr      <= 1'b0;
            tx_udr      <= 1'b0;
            enable      <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= '0;
`ifdef SPI_TARGET_IRQ_EN
            ie_rx       <= 1'b0;
            ie_tx       <= 1'b0;
            ie_err      <= 1'b0;
            irq         <= 1'b0;
`endif
        end else begin
            ss_sync     <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            sck_sync    <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            ss_d        <= ss_s_c;
            sck_d       <= sck_s_c;

            wb.wb_ack_o <= acc_c;
            wb.wb_dat_o <= (acc_c & ~wb.wb_we_i) ? rd_data_c : '0;

            if (ctrl_wr_c) begin
                enable <= wb.wb_dat_i[0];
`ifdef SPI_TARGET_IRQ_EN
                ie_rx  <= wb.wb_dat_i[1];
                ie_tx  <= wb.wb_dat_i[2];
                ie_err <= wb.wb_dat_i[3];
`endif
            end

            if (data_wr_c) begin
                tx_hold <= wb.wb_dat_i[BYTE_W-1:0];
            end

            // Set conditions take priority over software clears
            if (data_wr_c) begin
                tx_full <= 1'b1;
            end else if (reload_c) begin
                tx_full <= 1'b0;
            end

            if (reload_c & ~tx_full) begin
                tx_udr <= 1'b1;
            end else if (stat_wr_c & wb.wb_dat_i[3]) begin
                tx_udr <= 1'b0;
            end

            if (byte_done_c & ~rx_take_c) begin
                rx_ovr <= 1'b1;
            end else if (stat_wr_c & wb.wb_dat_i[2]) begin
                rx_ovr <= 1'b0;
            end

            if (rx_take_c) begin
                rx_valid <= 1'b1;
                rx_data  <= rx_byte_c;
            end else if (data_rd_c) begin
                rx_valid <= 1'b0;
            end

            // Frame state and shift path
            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        state       <= ST_SEL;
                        bit_cnt     <= '0;
                        rx_shift    <= '0;
                        tx_shift    <= reload_val_c;
                        spi_miso    <= reload_val_c[BYTE_W-1];
                        spi_miso_oe <= 1'b1;
                    end
                end
                ST_SEL: begin
                    if (leave_c) begin
                        state       <= ST_IDLE;
                        bit_cnt     <= '0;
                        rx_shift    <= '0;
                        spi_miso    <= 1'b0;
                        spi_miso_oe <= 1'b0;
                    end else begin
                        if (rise_c) begin
                            rx_shift <= rx_byte_c;
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                        end
                        if (fall_c) begin
                            if (bit_cnt == CNT_W'(0)) begin
                                tx_shift <= reload_val_c;
                                spi_miso <= reload_val_c[BYTE_W-1];
                            end else begin
                                tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                                spi_miso <= tx_shift[BYTE_W-2];
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

`ifdef SPI_TARGET_IRQ_EN
            irq <= enable & ((ie_rx & rx_valid) | (ie_tx & ~tx_full) |
                             (ie_err & (rx_ovr | tx_udr)));
`endif
        end
    end

endmodule

// File: tb/tb_spi_target_wb.sv
// Directed bench for spi_target_wb: bit-banged SPI controller plus Wishbone accesses.
module tb_spi_target_wb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic ss_n, sck, mosi;
    logic miso, miso_oe;
`ifdef SPI_TARGET_IRQ_EN
    logic irq;
`endif

    spi_target_wb_if wbi ();

    spi_target_wb dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb          (wbi),
        .spi_ss_n    (ss_n),
        .spi_sck     (sck),
        .spi_mosi    (mosi),
        .spi_miso    (miso),
        .spi_miso_oe (miso_oe)
`ifdef SPI_TARGET_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A_DATA = 32'h0;
    localparam logic [31:0] A_STAT = 32'h4;
    localparam logic [31:0] A_CTRL = 32'h8;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One Wishbone access; the ack itself is checked with a bounded wait
    task automatic wb_xfer(input logic [31:0] adr, input logic we,
                           input logic [31:0] wdat, output logic [31:0] rdat);
        int waitc;
        rdat          = '0;
        wbi.wb_adr_i  = adr;
        wbi.wb_dat_i  = wdat;
        wbi.wb_we_i   = we;
        wbi.wb_sel_i  = 4'hF;
        wbi.wb_cyc_i  = 1'b1;
        wbi.wb_stb_i  = 1'b1;
        waitc = 0;
        do begin
            @(posedge clk);
            #1;
            waitc++;
        end while (!wbi.wb_ack_o && waitc < 8);
        total++;
        if (wbi.wb_ack_o !== 1'b1) begin
            bad++;
            $display("FAIL wb_ack adr=%h: got %b want 1", adr, wbi.wb_ack_o);
        end
        rdat         = wbi.wb_dat_o;
        wbi.wb_cyc_i = 1'b0;
        wbi.wb_stb_i = 1'b0;
        wbi.wb_we_i  = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(adr, 1'b1, d, dummy);
    endtask

    task automatic wb_rd(input logic [31:0] adr, output logic [31:0] d);
        wb_xfer(adr, 1'b0, 32'h0, d);
    endtask

    // Clock n bits of tx MSB first at SCK = clk/16, sampling MISO before each rise
    task automatic spi_bits(input logic [7:0] tx, input int n, input bit last_fall,
                            output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            tick(8);
            rx  = {rx[6:0], miso};
            sck = 1'b1;
            tick(8);
            if (i < n - 1 || last_fall) sck = 1'b0;
        end
        if (last_fall) tick(8);
    endtask

    task automatic spi_sel();
        ss_n = 1'b0;
        tick(8);
    endtask

    task automatic spi_desel();
        sck  = 1'b0;
        ss_n = 1'b1;
        tick(8);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        total++;
        if (wbi.wb_ack_o !== 1'b0 || wbi.wb_dat_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_wb: got ack=%b dat=%h want 0/0", wbi.wb_ack_o, wbi.wb_dat_o);
        end
        total++;
        if (miso !== 1'b0 || miso_oe !== 1'b0) begin
            bad++;
            $display("FAIL reset_spi: got miso=%b oe=%b want 0/0", miso, miso_oe);
        end
        wb_rd(A_STAT, d);
        total++;
        if (d !== 32'h02) begin bad++; $display("FAIL reset_stat: got %h want 02", d); end
        wb_rd(A_CTRL, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [7:0] rx;
        wb_wr(A_CTRL, 32'h1);
        wb_wr(A_DATA, 32'hA5);
        wb_rd(A_STAT, d);
        total++;
        if (d !== 32'h00) begin bad++; $display("FAIL basic_stat_full: got %h want 00", d); end
        spi_sel();
        total++;
        if (miso_oe !== 1'b1) begin bad++; $display("FAIL basic_oe: got %b want 1", miso_oe); end
        spi_bits(8'h3C, 8, 1'b0, rx);
        total++;
        if (rx !== 8'hA5) begin bad++; $display("FAIL basic_miso: got %h want a5", rx); end
        wb_rd(A_STAT, d);
        total++;
        if (d !== 32'h13) begin bad++; $display("FAIL basic_stat_frame: got %h want 13", d); end
        sck = 1'b0;
        tick(8);
        spi_desel();
        total++;
        if (miso_oe !== 1'b0) begin bad++; $display("FAIL basic_oe_off: got %b want 0", miso_oe); end
        wb_rd(A_DATA, d);
        total++;
        if (d !== 32'h3C) begin bad++; $display("FAIL basic_data: got %h want 3c", d); end
        wb_rd(A_STAT, d);
        total++;
        if (d !== 32'h0A) begin bad++; $display("FAIL basic_stat_after: got %h want 0a", d); end
        wb_wr(A_STAT, 32'hC);
    endtask

    task automatic test_underrun_overrun();
        logic [31:0] d;
        logic [7:0] rx;
        spi_sel();
        spi_bits(8'h11, 8, 1'b1, rx);
        total++;
        if (rx !== 8'hFF) begin bad++; $display("FAIL udr_miso0: got %h want ff", rx); end
        spi_bits(8'h22, 8, 1'b1, rx);
        total++;
        if (rx !== 8'hFF) begin bad++; $display("FAIL udr_miso1: got %h want ff", rx); end
        spi_desel();
        wb_rd(A_STAT, d);
        total++;
        if (d !== 32'h0F) begin bad++; $display("FAIL ovr_stat: got %h want 0f", d); end
        wb_rd(A_DATA, d);
        total++;
        if (d !== 32'h11) begin bad++; $display("FAIL ovr_data: got %h want 11", d); end
        wb_wr(A_STAT, 32'hC);
        wb_rd(A_STAT, d);
        total++;
        if (d !== 32'h02) begin bad++; $display("FAIL ovr_clear: got %h want 02", d); end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        logic [7:0] rx;
        spi_sel();
        spi_bits(8'hF8, 5, 1'b1, rx);
        spi_desel();
        total++;
        if (miso_oe !== 1'b0) begin bad++; $display("FAIL abort_oe: got %b want 0", miso_oe); end
        wb_rd(A_STAT, d);
        total++;
        if (d !== 32'h0A) begin bad++; $display("FAIL abort_stat: got %h want 0a", d); end
        wb_wr(A_STAT, 32'hC);
        wb_wr(A_DATA, 32'h5A);
        spi_sel();
        spi_bits(8'h81, 8, 1'b1, rx);
        spi_desel();
        total++;
        if (rx !== 8'h5A) begin bad++; $display("FAIL abort_miso: got %h want 5a", rx); end
        wb_rd(A_DATA, d);
        total++;
        if (d !== 32'h81) begin bad++; $display("FAIL abort_data: got %h want 81", d); end
        wb_wr(A_STAT, 32'hC);
    endtask

    task automatic test_disable();
        logic [31:0] d;
        logic [7:0] rx;
        spi_sel();
        spi_bits(8'hE0, 3, 1'b1, rx);
        wb_wr(A_CTRL, 32'h0);
        tick(2);
        total++;
        if (miso_oe !== 1'b0) begin bad++; $display("FAIL dis_oe: got %b want 0", miso_oe); end
        wb_wr(A_CTRL, 32'h1);
        spi_bits(8'hC3, 8, 1'b1, rx);
        total++;
        if (miso_oe !== 1'b0) begin bad++; $display("FAIL dis_no_resume: got %b want 0", miso_oe); end
        spi_desel();
        wb_rd(A_STAT, d);
        total++;
        if (d !== 32'h0A) begin bad++; $display("FAIL dis_stat: got %h want 0a", d); end
        wb_wr(A_STAT, 32'hC);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0] rx;
        wb_wr(A_DATA, 32'h12);
        wb_wr(A_DATA, 32'h34);
        wb_rd(A_STAT, d);
        total++;
        if (d !== 32'h00) begin bad++; $display("FAIL b2b_stat: got %h want 00", d); end
        spi_sel();
        spi_bits(8'h00, 8, 1'b1, rx);
        spi_desel();
        total++;
        if (rx !== 8'h34) begin bad++; $display("FAIL b2b_miso: got %h want 34", rx); end
        wb_rd(A_DATA, d);
        total++;
        if (d !== 32'h00) begin bad++; $display("FAIL b2b_data: got %h want 00", d); end
        wb_wr(A_STAT, 32'hC);
    endtask

    task automatic test_simultaneous_read();
        logic [31:0] d;
        logic [7:0] rx;
        spi_sel();
        spi_bits(8'h42, 8, 1'b1, rx);
        spi_bits(8'h96, 7, 1'b1, rx);
        mosi = 1'b0;
        tick(8);
        sck = 1'b1;
        tick(2);
        // Access lands on the edge where the synchronised 8th rise is acted on
        wb_rd(A_DATA, d);
        total++;
        if (d !== 32'h42) begin bad++; $display("FAIL sim_rd_old: got %h want 42", d); end
        tick(2);
        wb_rd(A_STAT, d);
        total++;
        if ((d & 32'h5) !== 32'h1) begin
            bad++;
            $display("FAIL sim_rd_flags: got %h want valid=1 ovr=0", d & 32'h5);
        end
        sck = 1'b0;
        tick(8);
        spi_desel();
        wb_rd(A_DATA, d);
        total++;
        if (d !== 32'h96) begin bad++; $display("FAIL sim_rd_new: got %h want 96", d); end
        wb_wr(A_STAT, 32'hC);
    endtask

`ifdef SPI_TARGET_IRQ_EN
    task automatic test_irq();
        logic [31:0] d;
        logic [7:0] rx;
        wb_wr(A_CTRL, 32'h3);
        spi_sel();
        spi_bits(8'h55, 8, 1'b1, rx);
        spi_desel();
        tick(5);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL irq_set: got %b want 1", irq); end
        wb_rd(A_DATA, d);
        total++;
        if (d !== 32'h55) begin bad++; $display("FAIL irq_data: got %h want 55", d); end
        tick(1);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_clr: got %b want 0", irq); end
        wb_wr(A_CTRL, 32'h1);
        wb_wr(A_STAT, 32'hC);
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic [7:0] rx;
        wb_wr(A_DATA, 32'h77);
        spi_sel();
        spi_bits(8'hAA, 4, 1'b1, rx);
        total++;
        if (miso_oe !== 1'b1) begin bad++; $display("FAIL rst_pre_oe: got %b want 1", miso_oe); end
        rst = 1'b1;
        tick(1);
        total++;
        if (miso !== 1'b0 || miso_oe !== 1'b0 || wbi.wb_ack_o !== 1'b0 || wbi.wb_dat_o !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got miso=%b oe=%b ack=%b dat=%h want 0/0/0/0",
                     miso, miso_oe, wbi.wb_ack_o, wbi.wb_dat_o);
        end
        rst = 1'b0;
        tick(1);
        wb_rd(A_STAT, d);
        total++;
        if (d !== 32'h02) begin bad++; $display("FAIL rst_mid_stat: got %h want 02", d); end
        wb_rd(A_CTRL, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL rst_mid_ctrl: got %h want 0", d); end
        spi_desel();
    endtask

    initial begin
        rst          = 1'b1;
        ss_n         = 1'b1;
        sck          = 1'b0;
        mosi         = 1'b0;
        wbi.wb_adr_i = '0;
        wbi.wb_dat_i = '0;
        wbi.wb_we_i  = 1'b0;
        wbi.wb_sel_i = '0;
        wbi.wb_stb_i = 1'b0;
        wbi.wb_cyc_i = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        test_reset();
        test_basic();
        test_underrun_overrun();
        test_abort();
        test_disable();
        test_back_to_back();
        test_simultaneous_read();
`ifdef SPI_TARGET_IRQ_EN
        test_irq();
`endif
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
